vending_payment_ctrl: RTL and testbench

Transaction controller that sits downstream of the text-LCD menu stage. It consumes the menu's current product index and its select flag. It accepts coin pulses, holds a credit balance, and issues a dispense pulse when a purchase is covered. On cancel it pays the remaining credit back as a timed train of 500W/100W change pulses.

---
 rtl/vending_payment_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_vending_payment_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_payment_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vending_payment_ctrl
// Purpose  : Vending transaction controller. Accepts coins into a credit
//            balance, dispenses a product when a menu select edge is covered
//            by the credit, and pays remaining credit back as a timed train
//            of 500W/100W change pulses on cancel.
// Revision : 1.0 - initial release
// ============================================================================
module vending_payment_ctrl #(
  parameter int unsigned PRICE0     = 1000,
  parameter int unsigned PRICE1     = 1200,
  parameter int unsigned PRICE2     = 1500,
  parameter int unsigned BAL_MAX    = 9900,
  parameter int unsigned CHANGE_GAP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_100,
  input  logic        coin_500,
  input  logic        coin_1000,
  input  logic [1:0]  product_id,
  input  logic        selected,
  input  logic        cancel,
  output logic [13:0] balance,
  output logic        dispense,
  output logic [1:0]  dispense_id,
  output logic        change_500,
  output logic        change_100,
  output logic        coin_reject,
  output logic        insufficient,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  // Gap counter must hold 0..CHANGE_GAP; keep at least one bit.
  localparam int unsigned GAP_W = (CHANGE_GAP < 1) ? 1 : $clog2(CHANGE_GAP + 1);

  localparam logic [13:0]      c_price0   = 14'(PRICE0);
  localparam logic [13:0]      c_price1   = 14'(PRICE1);
  localparam logic [13:0]      c_price2   = 14'(PRICE2);
  localparam logic [14:0]      c_bal_max  = 15'(BAL_MAX);
  localparam logic [13:0]      c_coin_100 = 14'd100;
  localparam logic [13:0]      c_coin_500 = 14'd500;
  localparam logic [13:0]      c_coin_1k  = 14'd1000;
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(CHANGE_GAP);
  localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);

  // Registered state and outputs
  state_t           r_state;
  logic [13:0]      r_balance;
  logic             r_sel_prev;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_dispense;
  logic [1:0]       r_dispense_id;
  logic             r_change_500;
  logic             r_change_100;
  logic             r_coin_reject;
  logic             r_insufficient;
  logic             r_busy;

  // Next-state values
  state_t           w_nxt_state;
  logic [13:0]      w_nxt_balance;
  logic [GAP_W-1:0] w_nxt_gap_cnt;
  logic             w_nxt_dispense;
  logic [1:0]       w_nxt_dispense_id;
  logic             w_nxt_change_500;
  logic             w_nxt_change_100;
  logic             w_nxt_coin_reject;
  logic             w_nxt_insufficient;

  // Input decode
  logic             w_sel_edge;
  logic             w_any_coin;
  logic             w_multi_coin;
  logic [13:0]      w_coin_val;
  logic [14:0]      w_coin_sum;
  logic             w_coin_fits;
  logic [13:0]      w_credit_add;
  logic [13:0]      w_bal_plus;
  logic [13:0]      w_price;
  logic             w_price_ok;

  // Purchase requests are only the rising edge of the level select flag.
  assign w_sel_edge   = selected & ~r_sel_prev;

  assign w_any_coin   = coin_100 | coin_500 | coin_1000;
  assign w_multi_coin = (coin_100 & coin_500) | (coin_100 & coin_1000) |
                        (coin_500 & coin_1000);

  // Pick the winning coin by priority 1000 > 500 > 100.
  always_comb begin
    w_coin_val = 14'd0;
    if (coin_1000) begin
      w_coin_val = c_coin_1k;
    end else if (coin_500) begin
      w_coin_val = c_coin_500;
    end else if (coin_100) begin
      w_coin_val = c_coin_100;
    end
  end

  // One extra bit so the overflow comparison cannot wrap.
  assign w_coin_sum   = {1'b0, r_balance} + {1'b0, w_coin_val};
  assign w_coin_fits  = (w_coin_sum <= c_bal_max);
  assign w_credit_add = (w_any_coin && w_coin_fits) ? w_coin_val : 14'd0;
  // Bounded by BAL_MAX, so 14 bits never overflow.
  assign w_bal_plus   = r_balance + w_credit_add;

  // Price lookup for the product under the cursor; id 3 has no product.
  always_comb begin
    w_price = 14'd0;
    case (product_id)
      2'd0:    w_price = c_price0;
      2'd1:    w_price = c_price1;
      2'd2:    w_price = c_price2;
      default: w_price = 14'd0;
    endcase
  end

  // Purchase is judged against the balance before any same-cycle coin.
  assign w_price_ok = (product_id != 2'd3) && (r_balance >= w_price);

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    w_nxt_state        = r_state;
    w_nxt_balance      = r_balance;
    w_nxt_gap_cnt      = r_gap_cnt;
    w_nxt_dispense     = 1'b0;
    w_nxt_dispense_id  = r_dispense_id;
    w_nxt_change_500   = 1'b0;
    w_nxt_change_100   = 1'b0;
    w_nxt_coin_reject  = 1'b0;
    w_nxt_insufficient = 1'b0;

    case (r_state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (r_state == ST_CREDIT)) begin
          // Cancel wins over a purchase and refuses any coin this cycle.
          w_nxt_state       = ST_CHANGE;
          w_nxt_gap_cnt     = '0;
          w_nxt_coin_reject = w_any_coin;
        end else begin
          // Losing coins and an overflowing winner both raise one reject.
          w_nxt_coin_reject = w_multi_coin | (w_any_coin & ~w_coin_fits);
          if (w_sel_edge && w_price_ok) begin
            // Coin credit and price debit land together on entering VEND.
            w_nxt_state       = ST_VEND;
            w_nxt_balance     = w_bal_plus - w_price;
            w_nxt_dispense    = 1'b1;
            w_nxt_dispense_id = product_id;
          end else begin
            w_nxt_insufficient = w_sel_edge;
            w_nxt_balance      = w_bal_plus;
            w_nxt_state        = (w_bal_plus != 14'd0) ? ST_CREDIT : ST_IDLE;
          end
        end
      end

      ST_VEND: begin
        // Single-cycle dispense; requests and cancels are dropped here.
        w_nxt_coin_reject = w_any_coin;
        w_nxt_state       = (r_balance != 14'd0) ? ST_CREDIT : ST_IDLE;
      end

      ST_CHANGE: begin
        w_nxt_coin_reject = w_any_coin;
        if (r_balance == 14'd0) begin
          w_nxt_state = ST_IDLE;
        end else begin
          // Emit one coin when the gap counter wraps to zero.
          if (r_gap_cnt == '0) begin
            if (r_balance >= c_coin_500) begin
              w_nxt_change_500 = 1'b1;
              w_nxt_balance    = r_balance - c_coin_500;
            end else if (r_balance >= c_coin_100) begin
              w_nxt_change_100 = 1'b1;
              w_nxt_balance    = r_balance - c_coin_100;
            end
          end
          w_nxt_gap_cnt = (r_gap_cnt == c_gap_last) ? '0 : (r_gap_cnt + c_gap_one);
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State, balance and registered outputs; async reset abandons any payout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_balance      <= 14'd0;
      r_sel_prev     <= 1'b0;
      r_gap_cnt      <= '0;
      r_dispense     <= 1'b0;
      r_dispense_id  <= 2'd0;
      r_change_500   <= 1'b0;
      r_change_100   <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_insufficient <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_balance      <= w_nxt_balance;
      r_sel_prev     <= selected;
      r_gap_cnt      <= w_nxt_gap_cnt;
      r_dispense     <= w_nxt_dispense;
      r_dispense_id  <= w_nxt_dispense_id;
      r_change_500   <= w_nxt_change_500;
      r_change_100   <= w_nxt_change_100;
      r_coin_reject  <= w_nxt_coin_reject;
      r_insufficient <= w_nxt_insufficient;
      r_busy         <= (w_nxt_state == ST_VEND) || (w_nxt_state == ST_CHANGE);
    end
  end

  assign balance      = r_balance;
  assign dispense     = r_dispense;
  assign dispense_id  = r_dispense_id;
  assign change_500   = r_change_500;
  assign change_100   = r_change_100;
  assign coin_reject  = r_coin_reject;
  assign insufficient = r_insufficient;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vending_payment_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_payment_ctrl
// Purpose  : Self-checking bench for vending_payment_ctrl: directed vector
//            table, hand-written payout/reset sequences, and random traffic
//            checked against an event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vending_payment_ctrl;

  localparam int BAL_MAX = 9900;
  localparam int GAP     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_100, coin_500, coin_1000;
  logic [1:0]  product_id;
  logic        selected, cancel;
  logic [13:0] balance;
  logic        dispense;
  logic [1:0]  dispense_id;
  logic        change_500, change_100, coin_reject, insufficient, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vending_payment_ctrl dut (
    .clk(clk), .rst(rst),
    .coin_100(coin_100), .coin_500(coin_500), .coin_1000(coin_1000),
    .product_id(product_id), .selected(selected), .cancel(cancel),
    .balance(balance), .dispense(dispense), .dispense_id(dispense_id),
    .change_500(change_500), .change_100(change_100),
    .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy)
  );

  // Observation vector: {balance, dispense, id-if-dispense, c500, c100, reject, insufficient, busy}
  function automatic logic [21:0] pack_exp(int bal, bit disp, int id, bit c5, bit c1,
                                           bit rej, bit ins, bit bsy);
    logic [13:0] b;
    logic [1:0]  d;
    b = 14'(bal);
    d = disp ? 2'(id) : 2'b00;
    return {b, disp, d, c5, c1, rej, ins, bsy};
  endfunction

  function automatic logic [21:0] observe();
    return {balance, dispense, (dispense ? dispense_id : 2'b00), change_500, change_100,
            coin_reject, insufficient, busy};
  endfunction

  task automatic check_vec(input string name, input logic [21:0] exp);
    logic [21:0] act;
    act = observe();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual bal=%0d flags=%b required bal=%0d flags=%b",
               name, act[21:8], act[7:0], exp[21:8], exp[7:0]);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1ns after the edge.
  task automatic apply(input logic [2:0] coins, input logic [1:0] pid, input bit sel,
                       input bit can);
    {coin_1000, coin_500, coin_100} = coins;
    product_id = pid;
    selected   = sel;
    cancel     = can;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {coin_1000, coin_500, coin_100} = 3'b000;
    product_id = 2'd0; selected = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_vec("reset_state", pack_exp(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct { int step; bit is500; } pulse_t;
  pulse_t m_q[$];
  int     m_bal, m_busy_until, m_cyc;
  bit     m_prev;
  int     price_of[4] = '{1000, 1200, 1500, 0};

  task automatic model_reset();
    m_bal = 0; m_busy_until = -1; m_cyc = 0; m_prev = 1'b0;
    m_q.delete();
  endtask

  // Steps whose index is <= m_busy_until see the controller busy (inputs dropped).
  // A cancel schedules the whole payout up front as timed coin events.
  task automatic model_step(input logic [2:0] coins, input logic [1:0] pid, input bit sel,
                            input bit can, output logic [21:0] e);
    int coin, ncoins, add, price, n500, n100, s;
    bit edge_, disp, c5, c1, rej, ins;
    pulse_t p;
    disp = 0; c5 = 0; c1 = 0; rej = 0; ins = 0; add = 0;
    s = m_cyc;
    edge_  = sel && !m_prev;
    m_prev = sel;
    ncoins = int'(coins[0]) + int'(coins[1]) + int'(coins[2]);
    coin   = coins[2] ? 1000 : coins[1] ? 500 : coins[0] ? 100 : 0;
    if (s <= m_busy_until) begin
      rej = (coin != 0);
      if (m_q.size() > 0 && m_q[0].step == s) begin
        if (m_q[0].is500) begin c5 = 1; m_bal -= 500; end
        else              begin c1 = 1; m_bal -= 100; end
        void'(m_q.pop_front());
      end
    end else if (can && m_bal > 0) begin
      rej  = (coin != 0);
      n500 = m_bal / 500;
      n100 = (m_bal % 500) / 100;
      for (int i = 0; i < n500 + n100; i++) begin
        p.step  = s + 1 + (GAP + 1) * i;
        p.is500 = (i < n500);
        m_q.push_back(p);
      end
      m_busy_until = s + 1 + (GAP + 1) * (n500 + n100 - 1) + 1;
    end else begin
      rej   = (ncoins > 1) || (coin != 0 && m_bal + coin > BAL_MAX);
      add   = (coin != 0 && m_bal + coin <= BAL_MAX) ? coin : 0;
      price = price_of[pid];
      if (edge_ && (pid == 2'd3 || m_bal < price)) begin
        ins = 1; m_bal += add;
      end else if (edge_) begin
        m_bal = m_bal + add - price; disp = 1; m_busy_until = s + 1;
      end else begin
        m_bal += add;
      end
    end
    e = pack_exp(m_bal, disp, int'(pid), c5, c1, rej, ins, s < m_busy_until);
    m_cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  coins;   // {1000, 500, 100}
    logic [1:0]  pid;
    bit          sel;
    bit          can;
    logic [21:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic [2:0] coins, input logic [1:0] pid, input bit sel,
                             input bit can, input int bal, input bit disp, input int id,
                             input bit rej, input bit ins, input bit bsy);
    vec_t r;
    r.coins = coins; r.pid = pid; r.sel = sel; r.can = can;
    r.exp   = pack_exp(bal, disp, id, 0, 0, rej, ins, bsy);
    return r;
  endfunction

  initial begin
    logic [21:0] e;
    int          exp_bal;
    bit          sel_r;
    logic [2:0]  cr;
    logic [1:0]  pr;
    bit          kr;

    // cancel at zero credit, coins, purchase, held select, refusals
    tbl.push_back(v(3'b000, 2'd0, 0, 1,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b100, 2'd0, 0, 0, 1000, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b010, 2'd0, 0, 0, 1500, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b000, 2'd1, 1, 0,  300, 1, 1, 0, 0, 1));
    tbl.push_back(v(3'b000, 2'd1, 1, 0,  300, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b000, 2'd1, 0, 0,  300, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b010, 2'd1, 0, 0,  800, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b001, 2'd1, 0, 0,  900, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b001, 2'd1, 0, 0, 1000, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b000, 2'd2, 1, 0, 1000, 0, 0, 0, 1, 0));
    tbl.push_back(v(3'b000, 2'd2, 0, 0, 1000, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b000, 2'd3, 1, 0, 1000, 0, 0, 0, 1, 0));
    tbl.push_back(v(3'b000, 2'd3, 0, 0, 1000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(3'b100, 2'd0, 0, 0, 2000 + 1000 * i, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b010, 2'd0, 0, 0, 9500, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b100, 2'd0, 0, 0, 9500, 0, 0, 1, 0, 0));  // overflow
    tbl.push_back(v(3'b011, 2'd0, 0, 0, 9500, 0, 0, 1, 0, 0));  // 500 wins, overflows
    tbl.push_back(v(3'b001, 2'd0, 0, 0, 9600, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b101, 2'd0, 0, 0, 9600, 0, 0, 1, 0, 0));  // 1000 wins, overflows
    tbl.push_back(v(3'b001, 2'd0, 0, 0, 9700, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b001, 2'd0, 0, 0, 9800, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'b001, 2'd0, 0, 0, 9900, 0, 0, 0, 0, 0));  // exactly BAL_MAX
    tbl.push_back(v(3'b001, 2'd0, 0, 0, 9900, 0, 0, 1, 0, 0));  // one over
    tbl.push_back(v(3'b100, 2'd0, 1, 0, 8900, 1, 0, 1, 0, 1));  // buy + refused coin
    tbl.push_back(v(3'b001, 2'd2, 0, 0, 8900, 0, 0, 1, 0, 0));  // coin during VEND
    tbl.push_back(v(3'b010, 2'd2, 1, 0, 7900, 1, 2, 0, 0, 1));  // buy + credited coin
    tbl.push_back(v(3'b000, 2'd2, 0, 0, 7900, 0, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].coins, tbl[i].pid, tbl[i].sel, tbl[i].can);
      check_vec($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Cancel at 1300 with a same-cycle purchase and coin, then timed payout.
    do_reset();
    apply(3'b100, 2'd0, 0, 0);
    apply(3'b001, 2'd0, 0, 0);
    apply(3'b001, 2'd0, 0, 0);
    apply(3'b001, 2'd0, 0, 0);
    check_vec("credit_1300", pack_exp(1300, 0, 0, 0, 0, 0, 0, 0));
    apply(3'b001, 2'd0, 1, 1);
    check_vec("cancel_beats_buy", pack_exp(1300, 0, 0, 0, 0, 1, 0, 1));
    exp_bal = 1300;
    for (int k = 0; k < 20; k++) begin
      bit c5, c1;
      c5 = (k == 0) || (k == 4);
      c1 = (k == 8) || (k == 12) || (k == 16);
      if (c5) exp_bal -= 500;
      if (c1) exp_bal -= 100;
      apply((k == 2) ? 3'b001 : 3'b000, 2'd0, 0, 0);
      check_vec($sformatf("payout_k%0d", k),
                pack_exp(exp_bal, 0, 0, c5, c1, (k == 2), 0, (k < 17)));
    end

    // Async reset in the middle of a payout.
    do_reset();
    apply(3'b100, 2'd0, 0, 0);
    apply(3'b001, 2'd0, 0, 0);
    apply(3'b001, 2'd0, 0, 0);
    apply(3'b001, 2'd0, 0, 0);
    apply(3'b000, 2'd0, 0, 1);
    apply(3'b000, 2'd0, 0, 0);
    check_vec("first_change", pack_exp(800, 0, 0, 1, 0, 0, 0, 1));
    #1 rst = 1'b1;
    #1 check_vec("async_reset", pack_exp(0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      apply(3'b000, 2'd0, 0, 0);
      check_vec($sformatf("post_reset%0d", k), pack_exp(0, 0, 0, 0, 0, 0, 0, 0));
    end

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    sel_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      cr[0] = ($urandom_range(0, 4) == 0);
      cr[1] = ($urandom_range(0, 5) == 0);
      cr[2] = ($urandom_range(0, 6) == 0);
      pr    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sel_r = ~sel_r;
      kr    = ($urandom_range(0, 29) == 0);
      model_step(cr, pr, sel_r, kr, e);
      apply(cr, pr, sel_r, kr);
      check_vec($sformatf("rand%0d", n), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
